// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline stall controller.
// Tnew/Tuse are 2-bit cycle counts; TUSE_NONE marks an unused source operand.
package pipe_stall_ctrl_pkg;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  localparam logic [1:0]  TUSE_NONE  = 2'd3;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  typedef logic [4:0] reg_idx_t;
  typedef logic [1:0] tnew_t;

  typedef struct packed {
    reg_idx_t dst;
    tnew_t    tnew;
  } sb_slot_t;

  // A Tnew of zero stays zero as the producer moves down the pipe.
  function automatic tnew_t tnew_dec(input tnew_t t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction
endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Decode/execute-side signals seen by the stall controller.
// The controller connects as slave; the pipeline (or bench) drives it as master.
interface pipe_stall_ctrl_if
  import pipe_stall_ctrl_pkg::*;
#(parameter int CNT_W = CNT_W_DEF) ();
  logic             Req;
  reg_idx_t         D_rs;
  reg_idx_t         D_rt;
  tnew_t            D_Tuse_rs;
  tnew_t            D_Tuse_rt;
  reg_idx_t         D_RegWrite;
  tnew_t            D_Tnew;
  logic             D_is_md;
  logic             E_md_start;
  logic             E_md_is_div;
  logic             stall;
  logic             BUSY;
  logic [CNT_W-1:0] md_cnt;

  modport master (
    output Req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_RegWrite, D_Tnew,
           D_is_md, E_md_start, E_md_is_div,
    input  stall, BUSY, md_cnt
  );

  modport slave (
    input  Req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_RegWrite, D_Tnew,
           D_is_md, E_md_start, E_md_is_div,
    output stall, BUSY, md_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl_md_busy_counter.sv
// MDU busy window: loads the op latency when a mult/div leaves E, counts to zero.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             kill_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A committed op keeps counting through a flush; a start during busy is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
    else if (start_i && !kill_i)
      cnt_d = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall controller: E/M destination scoreboard, Tuse/Tnew hazard
// compare and MDU busy interlock, producing a single stall for PC and F/D.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stall_ctrl_if.slave  bus
);
  sb_slot_t         e_q, e_d, m_q, m_d;
  logic             hz_rs, hz_rt, hz_md, stall;
  logic             busy;
  logic [CNT_W-1:0] cnt;

  // Register 0 never matches; W stage is omitted since its Tnew is always 0.
  assign hz_rs = (bus.D_rs != '0) &&
                 ((e_q.dst == bus.D_rs && e_q.tnew > bus.D_Tuse_rs) ||
                  (m_q.dst == bus.D_rs && m_q.tnew > bus.D_Tuse_rs));
  assign hz_rt = (bus.D_rt != '0) &&
                 ((e_q.dst == bus.D_rt && e_q.tnew > bus.D_Tuse_rt) ||
                  (m_q.dst == bus.D_rt && m_q.tnew > bus.D_Tuse_rt));
  assign hz_md = bus.D_is_md && (busy || bus.E_md_start);

  // Req wins so the PC can take the handler vector this cycle.
  assign stall = (hz_rs || hz_rt || hz_md) && !bus.Req;

  always_comb begin
    e_d = '{dst: bus.D_RegWrite, tnew: bus.D_Tnew};
    m_d = '{dst: e_q.dst, tnew: tnew_dec(e_q.tnew)};
    if (stall) e_d = '0;
    if (bus.Req) begin
      e_d = '0;
      m_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_cnt (
    .clk      (clk),
    .reset    (reset),
    .start_i  (bus.E_md_start),
    .is_div_i (bus.E_md_is_div),
    .kill_i   (bus.Req),
    .busy_o   (busy),
    .cnt_o    (cnt)
  );

  assign bus.stall  = stall;
  assign bus.BUSY   = busy;
  assign bus.md_cnt = cnt;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed checks of the stall controller: load-use, $0, MDU window, Req, reset.
module tb_pipe_stall_ctrl;
  import pipe_stall_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  pipe_stall_ctrl_if #(.CNT_W(4)) bus ();

  pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // A new mult/div must never issue while the MDU is still busy.
  always @(posedge clk) begin
    if (!reset)
      assert (!(bus.E_md_start && !bus.Req && bus.md_cnt != 4'd0))
        else $error("md_start issued while md_cnt=%0d", bus.md_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Req = 0; bus.D_rs = 0; bus.D_rt = 0;
    bus.D_Tuse_rs = TUSE_NONE; bus.D_Tuse_rt = TUSE_NONE;
    bus.D_RegWrite = 0; bus.D_Tnew = 0; bus.D_is_md = 0;
    bus.E_md_start = 0; bus.E_md_is_div = 0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1; tick(); tick(); reset = 0; #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    tests++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
    tests++; if (bus.md_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", bus.md_cnt); end
  endtask

  task automatic test_load_use();
    idle();
    bus.D_RegWrite = 5'd8; bus.D_Tnew = 2'd2; #1;
    tick();
    bus.D_RegWrite = 5'd9; bus.D_Tnew = 2'd1; bus.D_rs = 5'd8; bus.D_Tuse_rs = 2'd1; #1;
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL load_use_stall got %b want 1", bus.stall); end
    tick();
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL load_use_release got %b want 0", bus.stall); end
    tick();
    bus.D_RegWrite = 5'd10; #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL load_use_second got %b want 0", bus.stall); end
    // rt picks up the addu still in E (Tnew 1) against Tuse 0
    bus.D_rt = 5'd9; bus.D_Tuse_rt = 2'd0; #1;
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL rt_hazard got %b want 1", bus.stall); end
    idle(); tick(); tick();
  endtask

  task automatic test_zero_dst();
    idle();
    bus.D_RegWrite = 5'd0; bus.D_Tnew = 2'd2; #1;
    tick();
    bus.D_rs = 5'd0; bus.D_Tuse_rs = 2'd0; bus.D_rt = 5'd0; bus.D_Tuse_rt = 2'd0; #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL zero_dst got %b want 0", bus.stall); end
    idle(); tick(); tick();
  endtask

  task automatic test_div_window();
    idle();
    bus.E_md_start = 1; bus.E_md_is_div = 1; bus.D_is_md = 1; #1;
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL div_issue_stall got %b want 1", bus.stall); end
    tick();
    bus.E_md_start = 0; bus.E_md_is_div = 0; #1;
    for (int i = 10; i >= 1; i--) begin
      tests++; if (bus.md_cnt !== 4'(i)) begin fails++; $display("FAIL div_cnt got %0d want %0d", bus.md_cnt, i); end
      tests++; if (bus.BUSY !== 1'b1) begin fails++; $display("FAIL div_busy got %b want 1 at cnt %0d", bus.BUSY, i); end
      tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL div_stall got %b want 1 at cnt %0d", bus.stall, i); end
      tick();
    end
    tests++; if (bus.md_cnt !== 4'd0) begin fails++; $display("FAIL div_end_cnt got %0d want 0", bus.md_cnt); end
    tests++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL div_end_busy got %b want 0", bus.BUSY); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL div_end_stall got %b want 0", bus.stall); end
    idle();
  endtask

  task automatic test_req_squash();
    idle();
    bus.E_md_start = 1; bus.Req = 1; #1;
    tick();
    idle();
    tests++; if (bus.md_cnt !== 4'd0) begin fails++; $display("FAIL squash_cnt got %0d want 0", bus.md_cnt); end
    bus.D_RegWrite = 5'd6; bus.D_Tnew = 2'd2; #1; tick();
    bus.D_RegWrite = 5'd5; bus.D_Tnew = 2'd2; #1; tick();
    bus.D_RegWrite = 5'd0; bus.D_Tnew = 2'd0;
    bus.D_rs = 5'd5; bus.D_Tuse_rs = 2'd0; #1;
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL pre_req_hazard got %b want 1", bus.stall); end
    bus.Req = 1; #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL req_override got %b want 0", bus.stall); end
    tick();
    bus.Req = 0; #1;
    tests++; if (dut.e_q !== 7'd0) begin fails++; $display("FAIL req_flush_e got %h want 0", dut.e_q); end
    tests++; if (dut.m_q !== 7'd0) begin fails++; $display("FAIL req_flush_m got %h want 0", dut.m_q); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL post_req_stall got %b want 0", bus.stall); end
    idle(); tick();
  endtask

  task automatic test_req_mid_mult();
    idle();
    bus.E_md_start = 1; bus.E_md_is_div = 0; #1;
    tick();
    idle();
    tests++; if (bus.md_cnt !== 4'd5) begin fails++; $display("FAIL mult_load got %0d want 5", bus.md_cnt); end
    tick(); tick();
    tests++; if (bus.md_cnt !== 4'd3) begin fails++; $display("FAIL mult_cnt3 got %0d want 3", bus.md_cnt); end
    bus.Req = 1; #1;
    tick();
    bus.Req = 0; #1;
    tests++; if (bus.md_cnt !== 4'd2) begin fails++; $display("FAIL req_mult_2 got %0d want 2", bus.md_cnt); end
    tick();
    tests++; if (bus.md_cnt !== 4'd1) begin fails++; $display("FAIL req_mult_1 got %0d want 1", bus.md_cnt); end
    tick();
    tests++; if (bus.md_cnt !== 4'd0) begin fails++; $display("FAIL req_mult_0 got %0d want 0", bus.md_cnt); end
    tests++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL req_mult_busy got %b want 0", bus.BUSY); end
  endtask

  task automatic test_reset_mid_op();
    idle();
    bus.E_md_start = 1; bus.E_md_is_div = 1; #1;
    tick();
    bus.E_md_start = 0; bus.E_md_is_div = 0;
    bus.D_RegWrite = 5'd12; bus.D_Tnew = 2'd3; #1;
    tick(); tick(); tick();
    tests++; if (bus.md_cnt !== 4'd7) begin fails++; $display("FAIL pre_reset_cnt got %0d want 7", bus.md_cnt); end
    tests++; if (dut.e_q !== {5'd12, 2'd3}) begin fails++; $display("FAIL pre_reset_e got %h want %h", dut.e_q, {5'd12, 2'd3}); end
    reset = 1; tick(); reset = 0;
    idle();
    bus.D_rs = 5'd12; bus.D_Tuse_rs = 2'd0; bus.D_is_md = 1; #1;
    tests++; if (bus.md_cnt !== 4'd0) begin fails++; $display("FAIL rst_mid_cnt got %0d want 0", bus.md_cnt); end
    tests++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", bus.BUSY); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL rst_mid_stall got %b want 0", bus.stall); end
    tests++; if (dut.e_q !== 7'd0 || dut.m_q !== 7'd0) begin fails++; $display("FAIL rst_mid_slots got e=%h m=%h want 0", dut.e_q, dut.m_q); end
    idle();
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_load_use();
    test_zero_dst();
    test_div_window();
    test_req_squash();
    test_req_mid_mult();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall controller for the 5-stage pipeline.
- Keeps a shadow scoreboard of destination register and Tnew for the E and M stages, fed from D-stage decode.
- Sequences the multiply/divide unit busy window.
- Drives the single `stall` (freeze PC and F/D, bubble into D/E) and `BUSY` to the E/M pipeline registers and the MDU.
- `Req` (exception/interrupt taken at M) flushes the scoreboard to match the flushed pipeline registers.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu.
- DIV_CYCLES, 10, busy cycles loaded for div/divu.
- CNT_W, 4, busy counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- Req  in  1  exception/interrupt taken this cycle; flushes all stages.
- D_rs  in  5  rs index of the D-stage instruction.
- D_rt  in  5  rt index of the D-stage instruction.
- D_Tuse_rs  in  2  cycles until rs is needed (3 = not used).
- D_Tuse_rt  in  2  cycles until rt is needed (3 = not used).
- D_RegWrite  in  5  destination of the D-stage instruction (0 = none).
- D_Tnew  in  2  Tnew of the D-stage instruction measured at E.
- D_is_md  in  1  D instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- E_md_start  in  1  E-stage mult/div issuing this cycle.
- E_md_is_div  in  1  qualifies E_md_start: 1 = div, 0 = mult.
- stall  out  1  freeze PC and F/D; insert bubble into D/E.
- BUSY  out  1  MDU busy (counter nonzero).
- md_cnt  out  CNT_W  remaining MDU busy cycles.

Behaviour:
- Reset (clk edge with reset=1): E_dst=0, E_tnew=0, M_dst=0, M_tnew=0, md_cnt=0. Consequently stall=0 and BUSY=0 in the following cycle.
- Scoreboard update on each edge, evaluated in priority order:
  - reset or Req: all slots cleared.
  - else if stall: E slot gets dst=0, tnew=0 (bubble); M slot gets the old E slot with tnew saturating-decremented.
  - else: E slot gets {D_RegWrite, D_Tnew}; M slot gets the old E slot with tnew = max(E_tnew-1, 0).
- Data hazard, combinational, per source s in {rs, rt}:
  - hz_s = (D_s != 0) && ((E_dst == D_s && E_tnew > D_Tuse_s) || (M_dst == D_s && M_tnew > D_Tuse_s)).
  - Register 0 never stalls.
  - The W stage never stalls (Tnew is always 0 there).
- MD hazard: hz_md = D_is_md && (BUSY || E_md_start).
- stall = (hz_rs || hz_rt || hz_md) && !Req. Req overrides stall so PC can load 0x4180.
- MD counter:
  - Load: E_md_start && !Req && md_cnt==0 loads DIV_CYCLES if E_md_is_div, else MULT_CYCLES.
  - Load occurs on the same edge the instruction leaves E, so BUSY rises the next cycle.
  - Decrement: md_cnt!=0 decrements by 1 each edge. BUSY = (md_cnt != 0).
  - E_md_start together with Req: no load (the E instruction is squashed).
  - Req while md_cnt!=0: counting continues (the operation is already committed).
  - E_md_start while md_cnt!=0: protocol violation, ignored with no reload. The bench flags it as an assertion.
- Latency: stall and hazards are combinational from inputs plus current slot state; scoreboard and counter update in 1 cycle.
- Unsigned compares throughout. Tnew decrement saturates at 0 and never wraps.

Decomposition:
- Shared package: Tuse/Tnew encodings (TUSE_NONE=3), MULT_CYCLES/DIV_CYCLES defaults, handler PC constant 0x4180.
- One sub-module, md_busy_counter: load/decrement counter driving BUSY and md_cnt.
- Scoreboard and hazard compare stay in the top module.

Test Plan:
- Load-use: D lw $8 (D_RegWrite=8, D_Tnew=2), then D addu with rs=8, Tuse=1 → stall=1 for exactly 1 cycle, then 0. A second addu one cycle later → no stall.
- $0 destination: D_RegWrite=0 with Tnew=2, next D uses rs=0 → stall stays 0.
- Div window: E_md_start=1, E_md_is_div=1 → md_cnt 10,9,…,1 then 0; BUSY high 10 cycles; D mflo (D_is_md=1) stalls all 10 cycles plus the issue cycle.
- Req squash: E_md_start=1 with Req=1 → md_cnt stays 0. Req with E_dst=5 and M_dst=6 → both slots 0 next cycle; stall=0 during Req even when hz_rs is true.
- Req mid-mult: mult started, Req at md_cnt=3 → continues 2,1,0.
- Reset mid-operation: reset at md_cnt=7 with nonzero slots → md_cnt=0, BUSY=0, slots 0, stall=0 the next cycle.
